eth_tx_arbiter: RTL and testbench



---
 rtl/eth_pkg.sv | 11 +
 rtl/eth_tx_arbiter_rr_pick.sv | 30 +++
 rtl/eth_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and widths for the Ethernet TX frame arbiter.
package eth_pkg;
    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;
endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last,
// wrapping modulo N_SRC.
module rr_pick #(
    parameter int N_SRC = 2,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_SRC-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx
);
    logic w_found;
    int   w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int i = 1; i <= N_SRC; i++) begin
            w_cand = int'(i_last) + i;
            if (w_cand >= N_SRC) w_cand = w_cand - N_SRC;
            if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_found                     = 1'b1;
                o_grant[w_cand[IDX_W-1:0]]  = 1'b1;
                o_idx                       = w_cand[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin arbiter feeding the MAC TX AXI-Stream port, with
// max-length truncation and saturating truncation / mid-frame-gap statistics.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int MAX_BEATS = 190,
    parameter int CNT_W     = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [N_SRC*AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [N_SRC*AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic [N_SRC-1:0]             s_axis_tvalid,
    input  logic [N_SRC-1:0]             s_axis_tlast,
    output logic [N_SRC-1:0]             s_axis_tready,
    output logic [AXIS_DATA_W-1:0]       m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0]       m_axis_tkeep,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [N_SRC-1:0]             o_grant,
    output logic                         o_busy,
    output logic [CNT_W-1:0]             o_trunc_count,
    output logic [CNT_W-1:0]             o_gap_count,
    output arb_state_e                   o_state
);
    localparam int IDX_W  = $clog2(N_SRC);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    // Handshake rule on every AXIS port: a beat moves on a rising edge where
    // tvalid and tready are both high; a valid beat is held until accepted.
    arb_state_e       r_state, w_next_state;
    logic [N_SRC-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic             r_gap_flag;
    logic [CNT_W-1:0] r_trunc_count, r_gap_count;

    logic [N_SRC-1:0]       w_pick_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [AXIS_DATA_W-1:0] w_src_data [N_SRC];
    logic [AXIS_KEEP_W-1:0] w_src_keep [N_SRC];
    logic w_src_valid, w_src_last, w_last_beat, w_hs, w_frame_end, w_trunc;

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign w_src_data[k] = s_axis_tdata[k*AXIS_DATA_W +: AXIS_DATA_W];
        assign w_src_keep[k] = s_axis_tkeep[k*AXIS_KEEP_W +: AXIS_KEEP_W];
    end

    assign w_src_valid = s_axis_tvalid[r_last_grant];
    assign w_src_last  = s_axis_tlast[r_last_grant];

    rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
        .i_req   (s_axis_tvalid),
        .i_last  (r_last_grant),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        w_hs          = 1'b0;
        w_frame_end   = 1'b0;
        w_trunc       = 1'b0;
        w_last_beat   = (r_beat_cnt == BEAT_W'(MAX_BEATS - 1));
        case (r_state)
            ST_IDLE: begin
                if (|s_axis_tvalid) w_next_state = ST_SEND;
            end
            ST_SEND: begin
                m_axis_tdata                = w_src_data[r_last_grant];
                m_axis_tkeep                = w_src_keep[r_last_grant];
                m_axis_tvalid               = w_src_valid;
                m_axis_tlast                = w_src_last | w_last_beat;
                s_axis_tready[r_last_grant] = m_axis_tready;
                w_hs                        = w_src_valid & m_axis_tready;
                // A real source tlast wins over the length limit.
                if (w_hs && w_src_last) begin
                    w_next_state = ST_IDLE;
                    w_frame_end  = 1'b1;
                end else if (w_hs && w_last_beat) begin
                    w_next_state = ST_DRAIN;
                    w_frame_end  = 1'b1;
                    w_trunc      = 1'b1;
                end
            end
            ST_DRAIN: begin
                s_axis_tready[r_last_grant] = 1'b1;
                if (w_src_valid && w_src_last) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_grant       <= '0;
            r_last_grant  <= IDX_W'(N_SRC - 1);
            r_beat_cnt    <= '0;
            r_gap_flag    <= 1'b0;
            r_trunc_count <= '0;
            r_gap_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|s_axis_tvalid) begin
                        r_grant      <= w_pick_grant;
                        r_last_grant <= w_pick_idx;
                        r_beat_cnt   <= '0;
                        r_gap_flag   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_hs) r_beat_cnt <= r_beat_cnt + 1'b1;
                    if (!w_src_valid && r_beat_cnt != '0) r_gap_flag <= 1'b1;
                    if (w_frame_end && w_next_state == ST_IDLE) r_grant <= '0;
                    if (w_frame_end && r_gap_flag && r_gap_count != '1)
                        r_gap_count <= r_gap_count + 1'b1;
                    if (w_trunc && r_trunc_count != '1)
                        r_trunc_count <= r_trunc_count + 1'b1;
                end
                ST_DRAIN: begin
                    if (w_next_state == ST_IDLE) r_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_trunc_count = r_trunc_count;
    assign o_gap_count   = r_gap_count;
    assign o_state       = r_state;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomised bench for eth_tx_arbiter: frame-level reference model predicts
// grants, delivered beats (after truncation) and statistics counters.
module tb_eth_tx_arbiter;
    import eth_pkg::*;

    localparam int N     = 3;
    localparam int MAXB  = 4;
    localparam int CW    = 3;
    localparam int EXP_W = N + 64 + 8 + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*64-1:0] s_tdata;
    logic [N*8-1:0]  s_tkeep;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [63:0]     m_tdata;
    logic [7:0]      m_tkeep;
    logic            m_tvalid, m_tlast, m_tready;
    logic [N-1:0]    grant;
    logic            busy;
    logic [CW-1:0]   trunc_cnt, gap_cnt;
    arb_state_e      dbg_state;

    eth_tx_arbiter #(.N_SRC(N), .MAX_BEATS(MAXB), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .o_grant(grant), .o_busy(busy), .o_trunc_count(trunc_cnt),
        .o_gap_count(gap_cnt), .o_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int src; int len; int gap_at; int gap_len; int pre_idle; int id;
        logic [7:0] keep_last;
    } frame_t;

    frame_t           all_q[$];
    frame_t           cur_f[N];
    bit               active[N];
    int               beat[N];
    int               wait_c[N];
    bit               gap_done[N];
    logic [N-1:0]     hs_s;
    logic [EXP_W-1:0] exp_q[$];

    int n_cmp = 0, n_err = 0, cyc = 0, next_id = 0;
    bit model_busy = 0;
    int model_g = 0, last_pick = N - 1, exp_trunc = 0, exp_gap = 0;
    int ready_mode = 0, last_end_cyc = -1;
    bit ready_tog = 0, bubble_chk = 0, mon_in_frame = 0, prev_stall = 0;
    logic [72:0] held;

    function automatic logic [63:0] beat_data(input int id, input int b);
        return {16'(id), 16'(b), 32'(id) ^ 32'hC0DE_0000};
    endfunction

    function automatic int sat(input int v);
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First requester after the previous winner, counting round the ring.
    function automatic int rr_expect(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last + i) % N;
            if (req[c]) return c;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic add_frame(input int src, input int len, input int gap_at,
                             input int gap_len, input int pre_idle);
        frame_t f;
        f.src = src; f.len = len; f.gap_at = gap_at; f.gap_len = gap_len;
        f.pre_idle = pre_idle; f.id = next_id++;
        f.keep_last = 8'($urandom_range(1, 255));
        all_q.push_back(f);
    endtask

    task automatic drive_sources();
        for (int k = 0; k < N; k++) begin
            bit v;
            v = 1'b0;
            if (active[k] && hs_s[k]) begin
                beat[k]++;
                if (beat[k] == cur_f[k].len) active[k] = 1'b0;
            end
            if (!active[k]) begin
                for (int i = 0; i < all_q.size(); i++) begin
                    if (all_q[i].src == k) begin
                        cur_f[k] = all_q[i];
                        all_q.delete(i);
                        active[k] = 1'b1; beat[k] = 0;
                        wait_c[k] = cur_f[k].pre_idle; gap_done[k] = 1'b0;
                        break;
                    end
                end
            end
            if (active[k]) begin
                if (wait_c[k] > 0) wait_c[k]--;
                else if (!gap_done[k] && cur_f[k].gap_len > 0 && beat[k] == cur_f[k].gap_at) begin
                    gap_done[k] = 1'b1;
                    wait_c[k] = cur_f[k].gap_len - 1;
                end else v = 1'b1;
            end
            s_tvalid[k] = v;
            s_tlast[k]  = active[k] && (beat[k] == cur_f[k].len - 1);
            s_tdata[k*64 +: 64] = active[k] ? beat_data(cur_f[k].id, beat[k]) : 64'd0;
            s_tkeep[k*8 +: 8]   = s_tlast[k] ? cur_f[k].keep_last : 8'hFF;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check("grant", {busy, grant}, model_busy ? {1'b1, onehot(model_g)} : '0);
        hs_s = s_tvalid & s_tready;
        if (m_tvalid && prev_stall) check("stall_hold", {m_tdata, m_tkeep, m_tlast}, held);
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 1);
            else check("beat", {grant, m_tdata, m_tkeep, m_tlast}, exp_q.pop_front());
            if (!mon_in_frame) begin
                if (bubble_chk && last_end_cyc >= 0) check("bubble", 32'(cyc - last_end_cyc), 2);
                mon_in_frame = 1'b1;
            end
            if (m_tlast) begin
                mon_in_frame = 1'b0;
                last_end_cyc = cyc;
            end
        end
        prev_stall = m_tvalid && !m_tready;
        held = {m_tdata, m_tkeep, m_tlast};
        if (model_busy) begin
            if (hs_s[model_g] && beat[model_g] == cur_f[model_g].len - 1) model_busy = 1'b0;
        end else if (|s_tvalid) begin
            int p;
            p = rr_expect(s_tvalid, last_pick);
            model_busy = 1'b1; model_g = p; last_pick = p;
            for (int b = 0; b < cur_f[p].len && b < MAXB; b++) begin
                logic lst;
                logic [7:0] kp;
                lst = (b == cur_f[p].len - 1) || (b == MAXB - 1);
                kp  = (b == cur_f[p].len - 1) ? cur_f[p].keep_last : 8'hFF;
                exp_q.push_back({onehot(p), beat_data(cur_f[p].id, b), kp, lst});
            end
            if (cur_f[p].len > MAXB) exp_trunc++;
            if (cur_f[p].gap_len > 0 && cur_f[p].gap_at < MAXB) exp_gap++;
        end
        @(posedge clk);
        #1;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: begin ready_tog = ~ready_tog; m_tready = ready_tog; end
            default: m_tready = 1'(($urandom_range(0, 3) != 0));
        endcase
        drive_sources();
    endtask

    function automatic bit all_idle();
        bit any_act;
        any_act = 1'b0;
        for (int k = 0; k < N; k++) any_act |= active[k];
        return all_q.size() == 0 && !any_act && !model_busy && exp_q.size() == 0;
    endfunction

    task automatic run_phase(input string tag, input int budget);
        int n;
        n = 0;
        last_end_cyc = -1;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, 32'(all_idle()), 1);
        check({tag, "_trunc"}, 32'(trunc_cnt), sat(exp_trunc));
        check({tag, "_gap"}, 32'(gap_cnt), sat(exp_gap));
    endtask

    initial begin
        rst_n = 1'b0; m_tready = 1'b1;
        s_tvalid = '1; s_tlast = '1; s_tdata = '1; s_tkeep = '1;
        hs_s = '0;
        for (int k = 0; k < N; k++) begin active[k] = 0; beat[k] = 0; wait_c[k] = 0; gap_done[k] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", {m_tdata, m_tkeep}, 0);
        check("rst_counts", {trunc_cnt, gap_cnt}, 0);
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        add_frame(0, 3, 0, 0, 0);
        run_phase("single", 200);

        for (int i = 0; i < 4; i++) begin
            add_frame(0, 2, 0, 0, 0);
            add_frame(1, 2, 0, 0, 0);
        end
        bubble_chk = 1'b1;
        run_phase("rr_pair", 400);
        bubble_chk = 1'b0;

        add_frame(1, 7, 0, 0, 0);
        run_phase("trunc", 200);
        add_frame(0, 4, 0, 0, 0);
        run_phase("exact_max", 200);

        add_frame(0, 4, 2, 2, 0);
        run_phase("gap", 200);
        ready_mode = 1;
        add_frame(0, 4, 2, 2, 0);
        add_frame(1, 4, 0, 0, 0);
        add_frame(2, 7, 5, 2, 0);
        run_phase("gap_toggle", 300);

        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int len, ga, gl;
            len = $urandom_range(1, 7);
            ga = 0; gl = 0;
            if (len > 1 && $urandom_range(0, 1) == 1) begin
                ga = $urandom_range(1, len - 1);
                gl = $urandom_range(1, 3);
            end
            add_frame($urandom_range(0, N - 1), len, ga, gl, $urandom_range(0, 2));
        end
        run_phase("random", 3000);

        // Reset in the middle of a frame, then check first-pick after release.
        ready_mode = 0;
        @(posedge clk); #1;
        m_tready = 1'b1;
        s_tvalid = 3'b001; s_tlast = '0; s_tkeep = '1;
        s_tdata = '0; s_tdata[63:0] = beat_data(900, 0);
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        s_tdata[63:0] = beat_data(900, 1);
        @(negedge clk);
        check("pre_rst_grant", grant, 3'b001);
        check("pre_rst_data", m_tdata, beat_data(900, 1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_m_tvalid", m_tvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_s_tready", s_tready, 0);
        check("mid_rst_counts", {trunc_cnt, gap_cnt}, 0);
        @(posedge clk); #1;
        s_tvalid = 3'b011;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant", grant, onehot(rr_expect(3'b011, N - 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
